// File: rtl/alu_seg_scan.sv
// Registered 2-input ALU whose result is shown as hex digits on a multiplexed
// seven-segment display, with optional leading-zero blanking.
module alu_seg_scan #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 1000,
  parameter int LZB      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           op,
  input  logic                 load,
  input  logic                 en,
  output logic [6:0]           seg,
  output logic [WIDTH/4-1:0]   an,
  output logic                 dp,
  output logic                 zero,
  output logic                 cout
);
  localparam int NDIG = WIDTH / 4;
  localparam int PW   = $clog2(SCAN_DIV);
  localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [6:0]       seg_q, seg_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic             dp_q, dp_d;
  logic             wrap;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = A - B;

  always_comb begin
    result_d = result_q;
    cout_d   = cout_q;
    if (load) begin
      case (op)
        OP_ADD:  begin result_d = sum[WIDTH-1:0]; cout_d = sum[WIDTH]; end
        OP_OR:   begin result_d = A | B;          cout_d = 1'b0;       end
        OP_SUB:  begin result_d = diff;           cout_d = (A < B);    end
        OP_XOR:  begin result_d = A ^ B;          cout_d = 1'b0;       end
        default: begin result_d = result_q;       cout_d = cout_q;     end
      endcase
    end
  end

  // Scan timing is free-running; en only gates what gets driven out.
  assign wrap    = (presc_q == PW'(SCAN_DIV - 1));
  assign presc_d = wrap ? '0 : presc_q + 1'b1;

  always_comb begin
    dig_d = dig_q;
    if (wrap) dig_d = (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + 1'b1;
  end

  logic [NDIG-1:0][6:0] dig_pat;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    if (LZB != 0 && i > 0) begin : g_blk
      // Blank only when this nibble and every higher one are zero.
      assign dig_pat[i] = (result_q[WIDTH-1:4*i] == '0) ? 7'd0
                                                         : hex7(result_q[4*i +: 4]);
    end else begin : g_raw
      assign dig_pat[i] = hex7(result_q[4*i +: 4]);
    end
  end

  always_comb begin
    seg_d = '0;
    an_d  = '0;
    dp_d  = 1'b0;
    if (en) begin
      seg_d = dig_pat[dig_q];
      an_d  = NDIG'(1) << dig_q;
      dp_d  = (dig_q == '0) & cout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      presc_q  <= '0;
      dig_q    <= '0;
      seg_q    <= '0;
      an_q     <= '0;
      dp_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      presc_q  <= presc_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign cout = cout_q;
  assign zero = (result_q == '0);

endmodule

// File: tb/tb_alu_seg_scan.sv
// Random and directed stimulus for alu_seg_scan against a cycle-count based
// model of the display scan (WIDTH=8, SCAN_DIV=4, LZB=1).
module tb_alu_seg_scan;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic [1:0] op;
  logic       load, en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp, zero, cout;

  int total = 0;
  int bad   = 0;

  // model state: edges since reset, result, carry/borrow
  int mcnt, mres, mcout;

  logic [6:0] PAT [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  alu_seg_scan #(.WIDTH(8), .SCAN_DIV(4), .LZB(1)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op), .load(load), .en(en),
    .seg(seg), .an(an), .dp(dp), .zero(zero), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mcnt = 0; mres = 0; mcout = 0;
  endtask

  // One clock: the display seen after the edge reflects the state before it.
  task automatic cycle();
    int dig, a, b;
    logic [6:0] es;
    logic [1:0] ea;
    logic       ed;
    dig = (mcnt / 4) % 2;
    es = '0; ea = '0; ed = 1'b0;
    if (en) begin
      ea = 2'(1 << dig);
      if (dig > 0 && (mres >> (4 * dig)) == 0) es = '0;
      else es = PAT[(mres >> (4 * dig)) & 15];
      ed = (dig == 0) ? mcout[0] : 1'b0;
    end
    @(posedge clk);
    mcnt++;
    if (load) begin
      a = int'(A); b = int'(B);
      case (op)
        2'b00: begin mres = (a + b) % 256; mcout = (a + b > 255) ? 1 : 0; end
        2'b01: begin mres = a | b;         mcout = 0; end
        2'b10: begin mres = (a - b + 256) % 256; mcout = (a < b) ? 1 : 0; end
        default: begin mres = a ^ b;       mcout = 0; end
      endcase
    end
    #1;
    chk("seg",  seg,  es);
    chk("an",   an,   ea);
    chk("dp",   dp,   ed);
    chk("zero", zero, (mres == 0) ? 1 : 0);
    chk("cout", cout, mcout);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    A = a; B = b; op = o; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; op = '0; load = 1'b0; en = 1'b0;
    model_reset();
    #12;
    chk("rst_seg", seg, 0); chk("rst_an", an, 0); chk("rst_dp", dp, 0);
    chk("rst_zero", zero, 1); chk("rst_cout", cout, 0);
    rst_n = 1'b1;

    // first edges after reset: digit 0 showing result 0
    en = 1'b1;
    repeat (3) cycle();

    // 3C + 05 = 41, no carry
    do_load(8'h3C, 8'h05, 2'b00);
    repeat (10) cycle();
    // 05 - 3C = C9 with borrow
    do_load(8'h05, 8'h3C, 2'b10);
    repeat (10) cycle();
    // FF + 01 = 00 with carry, digit 1 blanked
    do_load(8'hFF, 8'h01, 2'b00);
    repeat (10) cycle();

    // result 05 with en toggled off and back on
    do_load(8'h05, 8'h00, 2'b01);
    repeat (3) cycle();
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (6) cycle();

    // load landing on a digit advance
    while ((mcnt % 4) != 3) cycle();
    do_load(8'hA7, 8'h10, 2'b11);
    repeat (6) cycle();

    // async reset while digit 1 is displayed
    while ((mcnt % 8) < 5) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 0); chk("mid_rst_an", an, 0); chk("mid_rst_dp", dp, 0);
    chk("mid_rst_zero", zero, 1); chk("mid_rst_cout", cout, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (10) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      A    = 8'($urandom);
      B    = 8'($urandom);
      op   = 2'($urandom);
      load = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        A = 8'($urandom_range(0, 15)); B = 8'h00; op = 2'b01;
      end
      cycle();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
